// File: rtl/regfile_pkg.sv
// Shared definitions for the parametrised register file: sweep FSM states
// and the default geometry used when the top is instantiated bare.
package regfile_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } sweepState_e;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 32;
  localparam int DEF_NRD   = 2;

endpackage

// File: rtl/regfile_rd_port.sv
// One registered read port of the register file.
// Decodes the read address, returns zero for out-of-range addresses and for
// register 0 when it is hardwired, and registers the result.
// Optional feature: REGFILE_PARAM_BYPASS_EN forwards an accepted write whose
// address matches this port's read address straight to the output register.
module regfile_rd_port import regfile_pkg::*; #(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int AW      = $clog2(DEPTH),
  parameter int R0_ZERO = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [AW-1:0]    i_ra,
  input  logic [WIDTH-1:0] i_mem [DEPTH],
`ifdef REGFILE_PARAM_BYPASS_EN
  input  logic             i_wrAccept,
  input  logic [AW-1:0]    i_wa,
  input  logic [WIDTH-1:0] i_wd,
`endif
  output logic [WIDTH-1:0] o_rd
);

  localparam logic [AW:0] DEPTH_EXT = (AW+1)'(DEPTH);

  logic             w_inRange;
  logic             w_isZero;
  logic [WIDTH-1:0] w_rdNext;
  logic [WIDTH-1:0] r_rd;

  assign w_inRange = ({1'b0, i_ra} < DEPTH_EXT);
  assign w_isZero  = (R0_ZERO != 0) && (i_ra == '0);

  // Select the value this port will present after the next edge.
  always_comb begin
    w_rdNext = '0;
    if (w_inRange && !w_isZero) begin
      w_rdNext = i_mem[i_ra];
    end
`ifdef REGFILE_PARAM_BYPASS_EN
    // Accepted writes are already in range and never target a hardwired r0.
    if (i_wrAccept && (i_wa == i_ra)) begin
      w_rdNext = i_wd;
    end
`endif
  end

  // Output register giving the one-cycle read latency.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd <= '0;
    end else begin
      r_rd <= w_rdNext;
    end
  end

  assign o_rd = r_rd;

endmodule

// File: rtl/regfile_param.sv
// Parametrised multi-read-port register file with registered reads, optional
// hardwired-zero register 0 and a hardware sweep-clear sequencer.
// Optional feature: define REGFILE_PARAM_BYPASS_EN for write-to-read
// forwarding on every read port.
module regfile_param import regfile_pkg::*; #(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int NRD     = DEF_NRD,
  parameter int R0_ZERO = 1,
  parameter int AW      = $clog2(DEPTH)
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 We,
  input  logic [AW-1:0]        Wa,
  input  logic [WIDTH-1:0]     Wd,
  input  logic [NRD*AW-1:0]    Ra,
  output logic [NRD*WIDTH-1:0] Rd,
  input  logic                 Clr,
  output logic                 Busy
);

  localparam logic [AW:0]   DEPTH_EXT = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_IDX  = AW'(DEPTH-1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  sweepState_e      r_state;
  sweepState_e      w_nextState;
  logic [AW-1:0]    r_cnt;
  logic             w_waInRange;
  logic             w_wrAccept;
  logic             w_sweepLast;

  assign w_waInRange = ({1'b0, Wa} < DEPTH_EXT);
  assign w_wrAccept  = We && (r_state == IDLE) && w_waInRange &&
                       !((R0_ZERO != 0) && (Wa == '0));
  assign w_sweepLast = (r_state == SWEEP) && (r_cnt == LAST_IDX);
  assign Busy        = (r_state == SWEEP);

  // Sweep FSM state register.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next state: start a sweep on Clr, return to idle after the last entry; Clr is ignored mid-sweep.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (Clr)         w_nextState = SWEEP;
      SWEEP:   if (w_sweepLast) w_nextState = IDLE;
      default:                  w_nextState = IDLE;
    endcase
  end

  // Sweep counter walks 0..DEPTH-1 while sweeping and rests at 0 otherwise.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_cnt <= '0;
    end else if (r_state == SWEEP) begin
      r_cnt <= w_sweepLast ? '0 : r_cnt + 1'b1;
    end else begin
      r_cnt <= '0;
    end
  end

  // Storage: accepted writes land here, the sweep zeroes one entry per cycle.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_wrAccept) begin
        r_mem[Wa] <= Wd;
      end
      if (r_state == SWEEP) begin
        r_mem[r_cnt] <= '0;
      end
    end
  end

  for (genvar g = 0; g < NRD; g++) begin : g_rdPort
    regfile_rd_port #(
      .WIDTH   (WIDTH),
      .DEPTH   (DEPTH),
      .AW      (AW),
      .R0_ZERO (R0_ZERO)
    ) u_rdPort (
      .i_clk      (Clk),
      .i_rst      (Rst),
      .i_ra       (Ra[g*AW +: AW]),
      .i_mem      (r_mem),
`ifdef REGFILE_PARAM_BYPASS_EN
      .i_wrAccept (w_wrAccept),
      .i_wa       (Wa),
      .i_wd       (Wd),
`endif
      .o_rd       (Rd[g*WIDTH +: WIDTH])
    );
  end

endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised multi-read-port register file; successor to the fixed 32×32 flip-flop register bank. Adds configurable width, depth and read-port count, registered reads, hardwired-zero register 0, and a hardware sweep-clear sequencer with busy handshake. Sits in the CPU decode/writeback path and replaces the fixed bank plus its external read multiplexers.

## Interface
Parameters:
- WIDTH, 32, bits per register
- DEPTH, 32, number of registers (≥2)
- NRD, 2, number of read ports (≥1)
- AW, $clog2(DEPTH), address width (derived, not overridden)
- R0_ZERO, 1, register 0 reads 0 and ignores writes when 1

Ports:
- Clk  in  1  clock, rising edge
- Rst  in  1  reset, asynchronous, active-high
- We  in  1  write enable
- Wa  in  AW  write address
- Wd  in  WIDTH  write data
- Ra  in  NRD*AW  read addresses, port i at [i*AW +: AW]
- Rd  out  NRD*WIDTH  registered read data, port i at [i*WIDTH +: WIDTH]
- Clr  in  1  sweep-clear request, sampled at rising edge
- Busy  out  1  sweep in progress

## Operation
- Storage: DEPTH×WIDTH flip-flops; Rst forces every entry, Rd, Busy and sweep counter to 0 and FSM to IDLE.
- Write accepted when We=1, Busy=0, Wa<DEPTH, and not (R0_ZERO=1 and Wa=0). Otherwise dropped silently.
- Read port i: Rd_i ← mem[Ra_i] at each edge; Ra_i≥DEPTH → 0; Ra_i=0 with R0_ZERO=1 → 0. Ports independent; equal addresses allowed.
- FSM states IDLE, SWEEP. IDLE + Clr=1 → SWEEP, cnt=0. In SWEEP each cycle: mem[cnt]←0, cnt←cnt+1; when cnt=DEPTH-1 clear it and → IDLE. Clr in SWEEP ignored (no restart, no queue).
- Busy=1 exactly while state=SWEEP.
- Reads during SWEEP permitted; return current contents (already-cleared entries read 0).
- Clr and accepted write in same IDLE cycle: write lands, sweep then wipes it.
- Rst mid-sweep: immediate full clear, IDLE, Busy=0.

## Timing
- Read latency 1 cycle: Ra presented at edge N → Rd valid after edge N.
- Write visible to normal read path from edge N+1 (see Configuration for same-cycle).
- Busy rises after the edge sampling Clr, stays high DEPTH cycles, falls after edge clearing entry DEPTH-1; first write accepted on edge where Busy is already 0.
- Reset values: Rd=0 all ports, Busy=0.

## Configuration
- Macro REGFILE_PARAM_BYPASS_EN.
- Defined: write-to-read forwarding; if write accepted at edge N and Ra_i=Wa, Rd_i after edge N equals Wd.
- Undefined: Rd_i after edge N holds pre-write contents; new value seen from next read.
- Forwarding never applies to dropped writes (Busy, R0, out-of-range).

## Structure
- Package regfile_pkg: FSM state enum (IDLE, SWEEP), default WIDTH/DEPTH/NRD constants.
- Sub-module regfile_rd_port: one per read port via generate; address decode, range/zero check, optional bypass mux, output register.
- Sweep FSM, counter and storage in top.

## Test plan
- Reset: assert Rst mid-run → Rd=0, Busy=0, every address reads 0 after release.
- Write/read: write 0xDEADBEEF to r5, read r5 on port 0 and r5 on port 1 next cycle → both 0xDEADBEEF one cycle after Ra.
- R0/range: write 0x1234 to r0, read r0 → 0 (R0_ZERO=1); Ra=DEPTH (non-power-of-2 DEPTH=24) → 0.
- Bypass: write 0xA5A5A5A5 to r7 while Ra0=7 → Rd0=0xA5A5A5A5 with macro, prior value 0 without.
- Sweep: fill all regs with index+1, pulse Clr → Busy high exactly DEPTH cycles, writes during Busy dropped, all reads 0 afterwards; second Clr mid-sweep does not extend Busy.
- Reset mid-sweep: Rst at sweep cycle 10 → Busy=0 immediately, next Clr performs full DEPTH-cycle sweep.
